// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the 68000 interrupt controller: register map, source codes, FSM states.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package irq_ctrl_pkg;

    localparam int NUM_CH = 3;

    // Register word indices
    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_PEND   = 4'd1;
    localparam logic [3:0] REG_MASK   = 4'd2;
    localparam logic [3:0] REG_TS0_HI = 4'd4;
    localparam logic [3:0] REG_TS0_LO = 4'd5;
    localparam logic [3:0] REG_TS1_HI = 4'd6;
    localparam logic [3:0] REG_TS1_LO = 4'd7;
    localparam logic [3:0] REG_TS2_HI = 4'd8;
    localparam logic [3:0] REG_TS2_LO = 4'd9;

    // Channel source-select codes; anything else means "off"
    localparam logic [2:0] SEL_OFF    = 3'd0;
    localparam logic [2:0] SEL_VBLANK = 3'd1;
    localparam logic [2:0] SEL_HDMI   = 3'd2;
    localparam logic [2:0] SEL_USER   = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        IACK   = 2'd2
    } irq_state_t;

    // Selected source level for a channel nibble {invert, select}; an off channel stays 0
    // even when invert is set, so a disabled channel can never fire.
    function automatic logic sel_src(input logic [3:0] cfg, input logic [2:0] src);
        logic s;
        case (cfg[2:0])
            SEL_VBLANK: s = src[0] ^ cfg[3];
            SEL_HDMI:   s = src[1] ^ cfg[3];
            SEL_USER:   s = src[2] ^ cfg[3];
            default:    s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side bundle: register window plus 68000 interrupt/IACK handshake lines.
// Latency: n/a (wiring only).
// Backpressure: none; register accesses complete in the cycle they are presented.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic        cs;
    logic [1:0]  wr;
    logic [3:0]  address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        cpu_as_n;
    logic [2:0]  cpu_fc;
    logic [2:0]  cpu_lvl;
    logic [2:0]  ipl_n;
    logic        vpa_n;

    modport master (
        output cs, wr, address, din, cpu_as_n, cpu_fc, cpu_lvl,
        input  dout, ipl_n, vpa_n
    );

    modport slave (
        input  cs, wr, address, din, cpu_as_n, cpu_fc, cpu_lvl,
        output dout, ipl_n, vpa_n
    );

endinterface

// File: rtl/irq_channel.sv
// One interrupt channel: source select/invert, rising-edge detect, pending/overflow, tick capture.
// Latency: edge sampled at clock N, pending and timestamp updated at clock N+1.
// Backpressure: none; a clear coinciding with a new edge loses to the edge.
module irq_channel
    import irq_ctrl_pkg::*;
#(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          i_cfg,
    input  logic [3:0]          i_cfg_nxt,
    input  logic                i_reload,
    input  logic [2:0]          i_src,
    input  logic [TS_WIDTH-1:0] i_ticks,
    input  logic                i_clr_pend,
    input  logic                i_clr_ovf,
    output logic                o_pend,
    output logic                o_ovf,
    output logic [TS_WIDTH-1:0] o_ts
);

    logic                r_hist;
    logic                r_edge;
    logic                r_pend;
    logic                r_ovf;
    logic [TS_WIDTH-1:0] r_ts;
    logic                w_sig;
    logic                w_sig_nxt;
    logic                w_edge;

    assign w_sig     = sel_src(i_cfg, i_src);
    assign w_sig_nxt = sel_src(i_cfg_nxt, i_src);
    assign w_edge    = w_sig & ~r_hist;

    // History/edge register; a config change preloads history with the new selection so the
    // switch itself never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else if (i_reload) begin
            r_hist <= w_sig_nxt;
            r_edge <= 1'b0;
        end else begin
            r_hist <= w_sig;
            r_edge <= w_edge;
        end
    end

    // Pending/overflow/timestamp; a registered edge has priority over any clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
            r_ts   <= '0;
        end else if (r_edge) begin
            r_pend <= 1'b1;
            r_ts   <= i_ticks;
            if (r_pend)
                r_ovf <= 1'b1;
            else if (i_clr_ovf)
                r_ovf <= 1'b0;
        end else begin
            if (i_clr_pend)
                r_pend <= 1'b0;
            if (i_clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;
    assign o_ts   = r_ts;

endmodule

// File: rtl/irq_ctrl.sv
// 68000 interrupt controller: three edge channels, mask, priority encode to IPL, autovector IACK.
// Latency: edge at clock N -> pending at N+1 -> ipl_n at N+2; vpa_n one clock after IACK entry.
// Backpressure: none; register reads are combinational, writes take effect on the next edge.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          src,
    input  logic [TS_WIDTH-1:0] ticks,
    irq_ctrl_if.slave           bus
);

    logic [11:0]         r_ctrl;
    logic [2:0]          r_mask;
    logic                r_spur;
    logic [15:0]         r_shadow;
    irq_state_t          r_state;
    logic [2:0]          r_ipl_n;
    logic                r_vpa_n;

    logic [11:0]         w_ctrl_nxt;
    logic                w_ctrl_wr, w_pend_wr, w_mask_wr, w_rd;
    logic                w_iack_take, w_hit, w_spur_set;
    logic [2:0]          w_pend, w_ovf, w_reload, w_clr_pend, w_clr_ovf, w_iack_clr;
    logic [2:0]          w_unmasked, w_lvl, w_ipl_nxt;
    logic [TS_WIDTH-1:0] w_ts   [NUM_CH];
    logic [31:0]         w_ts32 [NUM_CH];
    logic                w_unused_din;

    assign w_ctrl_wr = bus.cs && (bus.address == REG_CTRL) && (bus.wr != 2'b00);
    assign w_pend_wr = bus.cs && (bus.address == REG_PEND);
    assign w_mask_wr = bus.cs && (bus.address == REG_MASK) && bus.wr[0];
    assign w_rd      = bus.cs && (bus.wr == 2'b00);

    // An IACK cycle is accepted from IDLE too, so an acknowledge with nothing pending is
    // still autovectored and flagged rather than hanging the CPU.
    assign w_iack_take = (bus.cpu_fc == 3'b111) && !bus.cpu_as_n && (r_state != IACK);

    // Byte-lane merge of a CTRL write and per-channel clear/reload strobes
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (bus.wr[0]) w_ctrl_nxt[7:0]  = bus.din[7:0];
        if (bus.wr[1]) w_ctrl_nxt[11:8] = bus.din[11:8];
        for (int n = 0; n < NUM_CH; n++) begin
            w_reload[n]   = w_ctrl_wr && (w_ctrl_nxt[4*n +: 4] != r_ctrl[4*n +: 4]);
            w_iack_clr[n] = w_iack_take && (bus.cpu_lvl == 3'(n + 1));
            w_clr_pend[n] = (w_pend_wr && bus.wr[0] && bus.din[n]) || w_iack_clr[n];
            w_clr_ovf[n]  = w_pend_wr && bus.wr[1] && bus.din[8 + n];
        end
    end

    assign w_hit      = |(w_iack_clr & w_pend);
    assign w_spur_set = w_iack_take && !w_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        irq_channel #(.TS_WIDTH(TS_WIDTH)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_cfg      (r_ctrl[4*g +: 4]),
            .i_cfg_nxt  (w_ctrl_nxt[4*g +: 4]),
            .i_reload   (w_reload[g]),
            .i_src      (src),
            .i_ticks    (ticks),
            .i_clr_pend (w_clr_pend[g]),
            .i_clr_ovf  (w_clr_ovf[g]),
            .o_pend     (w_pend[g]),
            .o_ovf      (w_ovf[g]),
            .o_ts       (w_ts[g])
        );
        assign w_ts32[g] = 32'(w_ts[g]);
    end

    // Priority encode: channel n is IPL level n+1, highest unmasked level wins
    assign w_unmasked = w_pend & r_mask;
    assign w_lvl      = w_unmasked[2] ? 3'd3 : w_unmasked[1] ? 3'd2 : w_unmasked[0] ? 3'd1 : 3'd0;
    assign w_ipl_nxt  = ~w_lvl;

    // CPU-writable registers, spurious flag and the timestamp lo shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl   <= '0;
            r_mask   <= '0;
            r_spur   <= 1'b0;
            r_shadow <= '0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= w_ctrl_nxt;
            if (w_mask_wr) r_mask <= bus.din[2:0];
            if (w_spur_set)
                r_spur <= 1'b1;
            else if (w_pend_wr && bus.wr[1] && bus.din[15])
                r_spur <= 1'b0;
            if (w_rd) begin
                case (bus.address)
                    REG_TS0_HI: r_shadow <= w_ts32[0][15:0];
                    REG_TS1_HI: r_shadow <= w_ts32[1][15:0];
                    REG_TS2_HI: r_shadow <= w_ts32[2][15:0];
                    default:    r_shadow <= r_shadow;
                endcase
            end
        end
    end

    // Interrupt FSM: IPL tracks the encoder outside IACK and is frozen during it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ipl_n <= 3'b111;
            r_vpa_n <= 1'b1;
        end else begin
            case (r_state)
                IDLE, ASSERT: begin
                    r_vpa_n <= 1'b1;
                    if (w_iack_take) begin
                        r_state <= IACK;
                    end else begin
                        r_ipl_n <= w_ipl_nxt;
                        r_state <= (|w_unmasked) ? ASSERT : IDLE;
                    end
                end
                IACK: begin
                    if (bus.cpu_as_n) begin
                        r_state <= IDLE;
                        r_vpa_n <= 1'b1;
                        r_ipl_n <= w_ipl_nxt;
                    end else begin
                        r_vpa_n <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read mux straight from address and registered state
    always_comb begin
        bus.dout = 16'h0000;
        case (bus.address)
            REG_CTRL:   bus.dout = {4'b0, r_ctrl};
            REG_PEND:   bus.dout = {r_spur, 4'b0, w_ovf, 5'b0, w_pend};
            REG_MASK:   bus.dout = {13'b0, r_mask};
            REG_TS0_HI: bus.dout = w_ts32[0][31:16];
            REG_TS1_HI: bus.dout = w_ts32[1][31:16];
            REG_TS2_HI: bus.dout = w_ts32[2][31:16];
            REG_TS0_LO,
            REG_TS1_LO,
            REG_TS2_LO: bus.dout = r_shadow;
            default:    bus.dout = 16'h0000;
        endcase
    end

    assign bus.ipl_n = r_ipl_n;
    assign bus.vpa_n = r_vpa_n;

    assign w_unused_din = &{1'b0, bus.din[14:12]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table plus directed interrupt/IACK sequences.
// Latency: stimulus changes 1ns after the rising edge, outputs sampled away from the edge.
// Backpressure: n/a.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  src;
    logic [31:0] ticks;

    irq_ctrl_if bus();

    irq_ctrl #(.TS_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .src     (src),
        .ticks   (ticks),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  waddr;
        logic [1:0]  wstb;
        logic [15:0] wdat;
        logic [3:0]  raddr;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ticks = ticks + 1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [1:0] s, input logic [15:0] d);
        bus.cs      = 1'b1;
        bus.wr      = s;
        bus.address = a;
        bus.din     = d;
        step();
        bus.cs = 1'b0;
        bus.wr = 2'b00;
    endtask

    // Expected value enters the scoreboard when the read is driven, and is popped and
    // compared once dout has settled mid-cycle.
    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string name);
        sb_t e;
        bus.cs      = 1'b1;
        bus.wr      = 2'b00;
        bus.address = a;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.name, bus.dout, e.exp);
        step();
        bus.cs = 1'b0;
    endtask

    task automatic iack_start(input logic [2:0] lvl);
        bus.cpu_fc   = 3'b111;
        bus.cpu_lvl  = lvl;
        bus.cpu_as_n = 1'b0;
    endtask

    task automatic iack_end();
        bus.cpu_as_n = 1'b1;
        bus.cpu_fc   = 3'b000;
        bus.cpu_lvl  = 3'b000;
    endtask

    initial begin
        logic [31:0] tr, ts1, ts2;

        vt[0] = '{REG_CTRL, 2'b11, 16'hFFFF, REG_CTRL, 16'h0FFF};
        vt[1] = '{REG_CTRL, 2'b01, 16'h0012, REG_CTRL, 16'h0F12};
        vt[2] = '{REG_CTRL, 2'b10, 16'h0300, REG_CTRL, 16'h0312};
        vt[3] = '{REG_CTRL, 2'b11, 16'h0000, REG_CTRL, 16'h0000};
        vt[4] = '{REG_MASK, 2'b11, 16'hFFFF, REG_MASK, 16'h0007};
        vt[5] = '{REG_MASK, 2'b01, 16'h0005, REG_MASK, 16'h0005};
        vt[6] = '{REG_MASK, 2'b10, 16'hFF00, REG_MASK, 16'h0005};
        vt[7] = '{4'd3,     2'b11, 16'hFFFF, 4'd3,     16'h0000};
        vt[8] = '{4'd15,    2'b11, 16'hFFFF, 4'd15,    16'h0000};
        vt[9] = '{REG_PEND, 2'b11, 16'hFFFF, REG_PEND, 16'h0000};

        reset_n      = 1'b0;
        src          = 3'b000;
        ticks        = 32'd0;
        bus.cs       = 1'b0;
        bus.wr       = 2'b00;
        bus.address  = 4'd0;
        bus.din      = 16'h0000;
        bus.cpu_as_n = 1'b1;
        bus.cpu_fc   = 3'b000;
        bus.cpu_lvl  = 3'b000;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("rst_ipl", {13'b0, bus.ipl_n}, 16'h0007);
        chk("rst_vpa", {15'b0, bus.vpa_n}, 16'h0001);
        rd(REG_CTRL,   16'h0000, "rst_ctrl");
        rd(REG_PEND,   16'h0000, "rst_pend");
        rd(REG_MASK,   16'h0000, "rst_mask");
        rd(REG_TS0_HI, 16'h0000, "rst_ts0_hi");
        rd(REG_TS1_LO, 16'h0000, "rst_shadow");

        // Register write/readback table
        for (int i = 0; i < 10; i++) begin
            wr_reg(vt[i].waddr, vt[i].wstb, vt[i].wdat);
            rd(vt[i].raddr, vt[i].exp, $sformatf("tbl%0d", i));
        end

        // Single src[0] edge at ticks=100: pending, ts=101, IPL two clocks after the edge
        wr_reg(REG_CTRL, 2'b11, 16'h0001);
        wr_reg(REG_MASK, 2'b11, 16'h0001);
        ticks = 32'd100;
        src   = 3'b001;
        step();
        chk("a_ipl_p1", {13'b0, bus.ipl_n}, 16'h0007);
        step();
        chk("a_ipl_p2", {13'b0, bus.ipl_n}, 16'h0007);
        step();
        chk("a_ipl_p3", {13'b0, bus.ipl_n}, 16'h0006);
        rd(REG_PEND,   16'h0001, "a_pend");
        rd(REG_TS0_HI, 16'h0000, "a_ts_hi");
        rd(REG_TS0_LO, 16'd101,  "a_ts_lo");

        // Second edge before ack: overflow, recapture; lo read returns the hi-read snapshot
        src = 3'b000;
        step();
        step();
        ticks = 32'h0002_FFFE;
        tr    = ticks;
        src   = 3'b001;
        step();
        step();
        ts1 = tr + 32'd1;
        rd(REG_PEND,   16'h0101,     "b_pend_ovf");
        rd(REG_TS0_HI, ts1[31:16],   "b_ts_hi");
        src = 3'b000;
        step();
        step();
        tr  = ticks;
        src = 3'b001;
        step();
        step();
        ts2 = tr + 32'd1;
        rd(REG_TS0_LO, ts1[15:0],    "b_ts_lo_shadow");
        rd(REG_TS0_HI, ts2[31:16],   "b_ts2_hi");
        rd(REG_TS0_LO, ts2[15:0],    "b_ts2_lo");
        wr_reg(REG_PEND, 2'b10, 16'h0100);
        rd(REG_PEND,   16'h0001,     "b_w1c_ovf");

        // Higher level arrives while asserting, then IACK for level 3
        wr_reg(REG_CTRL, 2'b11, 16'h0301);
        wr_reg(REG_MASK, 2'b11, 16'h0007);
        src = 3'b101;
        step();
        step();
        chk("c_ipl_before", {13'b0, bus.ipl_n}, 16'h0006);
        step();
        chk("c_ipl_raise", {13'b0, bus.ipl_n}, 16'h0004);
        rd(REG_PEND, 16'h0005, "c_pend_two");
        iack_start(3'd3);
        step();
        chk("c_vpa_entry", {15'b0, bus.vpa_n}, 16'h0001);
        step();
        chk("c_vpa_low", {15'b0, bus.vpa_n}, 16'h0000);
        chk("c_ipl_frozen", {13'b0, bus.ipl_n}, 16'h0004);
        rd(REG_PEND, 16'h0001, "c_pend_acked");
        iack_end();
        step();
        chk("c_vpa_release", {15'b0, bus.vpa_n}, 16'h0001);
        chk("c_ipl_after", {13'b0, bus.ipl_n}, 16'h0006);

        // Spurious IACK with nothing pending
        wr_reg(REG_PEND, 2'b11, 16'hFFFF);
        step();
        step();
        chk("d_ipl_idle", {13'b0, bus.ipl_n}, 16'h0007);
        rd(REG_PEND, 16'h0000, "d_pend_clear");
        iack_start(3'd2);
        step();
        step();
        chk("d_vpa_spur", {15'b0, bus.vpa_n}, 16'h0000);
        rd(REG_PEND, 16'h8000, "d_pend_spur");
        iack_end();
        step();
        chk("d_vpa_release", {15'b0, bus.vpa_n}, 16'h0001);
        wr_reg(REG_PEND, 2'b10, 16'h8000);
        rd(REG_PEND, 16'h0000, "d_spur_w1c");

        // New edge wins over a same-cycle W1C; masking keeps pending
        src[0] = 1'b0;
        step();
        src[0] = 1'b1;
        step();
        step();
        rd(REG_PEND, 16'h0001, "e_pend_first");
        src[0] = 1'b0;
        step();
        src[0] = 1'b1;
        step();
        bus.cs      = 1'b1;
        bus.address = REG_PEND;
        bus.wr      = 2'b01;
        bus.din     = 16'h0001;
        step();
        bus.cs = 1'b0;
        bus.wr = 2'b00;
        rd(REG_PEND, 16'h0101, "e_edge_beats_w1c");
        wr_reg(REG_MASK, 2'b11, 16'h0000);
        step();
        step();
        chk("e_mask_ipl", {13'b0, bus.ipl_n}, 16'h0007);
        rd(REG_PEND, 16'h0101, "e_mask_keeps");

        // CTRL change does not fabricate an edge; inverted source edge does fire
        wr_reg(REG_PEND, 2'b11, 16'hFFFF);
        src = 3'b111;
        step();
        step();
        wr_reg(REG_CTRL, 2'b11, 16'h0321);
        step();
        step();
        rd(REG_PEND, 16'h0000, "f_ctrl_no_edge");
        wr_reg(REG_CTRL, 2'b01, 16'h00A1);
        src[1] = 1'b0;
        step();
        step();
        rd(REG_PEND, 16'h0002, "f_invert_edge");

        // Reset in the middle of IACK releases vpa_n and ipl_n at once
        wr_reg(REG_MASK, 2'b11, 16'h0002);
        step();
        chk("g_ipl", {13'b0, bus.ipl_n}, 16'h0005);
        iack_start(3'd2);
        step();
        step();
        chk("g_vpa_low", {15'b0, bus.vpa_n}, 16'h0000);
        reset_n = 1'b0;
        #1;
        chk("g_rst_vpa", {15'b0, bus.vpa_n}, 16'h0001);
        chk("g_rst_ipl", {13'b0, bus.ipl_n}, 16'h0007);
        rd(REG_PEND, 16'h0000, "g_rst_pend");
        iack_end();
        reset_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: TS_WIDTH, 32, width of the tick timestamp captured per channel.
REQ-003 clk  in  1  system clock; all logic is clocked on the rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cs  in  1  register-window select from the CPU address decode.
REQ-006 wr  in  2  byte write strobes: bit1 = upper byte, bit0 = lower byte; qualified by cs.
REQ-007 address  in  4  word index of the register.
REQ-008 din  in  16  CPU write data.
REQ-009 dout  out  16  CPU read data.
REQ-010 src  in  3  raw interrupt sources, same clock domain: [0] VBlank, [1] hdmi_vblank, [2] user_in[1].
REQ-011 ticks  in  TS_WIDTH  free-running tick counter.
REQ-012 cpu_as_n  in  1  68000 address strobe.
REQ-013 cpu_fc  in  3  68000 function code.
REQ-014 cpu_lvl  in  3  CPU address bits [3:1]; carries the level during IACK.
REQ-015 ipl_n  out  3  68000 IPL2n..IPL0n.
REQ-016 vpa_n  out  1  autovector request during IACK.

Function
REQ-017 Registers: 0 CTRL (rw), 1 PEND (r / write-1-to-clear), 2 MASK (rw, bits [2:0]), 4/5 channel 0 timestamp hi/lo, 6/7 channel 1, 8/9 channel 2; any other index reads 0 and ignores writes.
REQ-018 CTRL: nibble n (bits 4n+3..4n) configures channel n; bits [2:0] = select (0 off, 1..3 = src[sel-1], 4..7 off), bit3 = invert; bits [15:12] read 0.
REQ-019 PEND: [2:0] pending, [10:8] overflow, [15] spurious-IACK flag; writing 1 clears the corresponding bit.
REQ-020 Channel n SHALL detect a rising edge of its selected, optionally inverted source, with the previous value registered each clock.
REQ-021 Latency: edge sampled in cycle N sets pending and captures ticks in cycle N+1; ipl_n updates in cycle N+2.
REQ-022 An edge while pending is already set SHALL set overflow and recapture the timestamp.
REQ-023 Changing CTRL SHALL reload the edge-detect history without producing an edge.
REQ-024 Channel n maps to IPL level n+1; ipl_n = ~(highest unmasked pending level), or 3'b111 if there is none.
REQ-025 State machine: IDLE -> ASSERT when any unmasked pending bit exists.
REQ-026 ASSERT -> IACK when cpu_fc==3'b111 and cpu_as_n==0.
REQ-027 ASSERT -> IDLE if all unmasked pending bits clear.
REQ-028 IACK -> IDLE when cpu_as_n returns high.
REQ-029 In ASSERT, ipl_n SHALL re-evaluate every cycle; a higher-level arrival raises it.
REQ-030 On entry to IACK: clear the pending bit for level cpu_lvl; vpa_n goes low the next cycle and stays low until cpu_as_n is high; ipl_n is held frozen during IACK.
REQ-031 A spurious IACK (cpu_lvl 0, or a level not pending) SHALL still assert vpa_n, clear nothing, and set PEND[15].
REQ-032 Simultaneous events: a new edge beats a same-cycle W1C or IACK clear, leaving pending set; masking never clears pending.
REQ-033 Reading a timestamp hi word SHALL snapshot the lo word into a shadow register; a lo read returns the shadow (atomic 32-bit read, hi first).
REQ-034 dout SHALL be combinational from address and registered state.

Reset
REQ-035 While reset_n is low: CTRL, MASK, PEND, timestamps, shadow and history = 0; state = IDLE; ipl_n = 3'b111; vpa_n = 1.
REQ-036 Reset mid-IACK SHALL release vpa_n immediately.

Structure
REQ-037 Package irq_ctrl_pkg SHALL hold the register index constants, source-select codes and the state enum (IDLE, ASSERT, IACK).
REQ-038 Sub-module irq_channel SHALL implement source select, invert, edge detect, pending, overflow and timestamp capture; it is instantiated three times.

Verification
REQ-039 CTRL=0x0001, MASK=1, ticks=100 at a src[0] rise -> PEND=0x0001, ts0=101, ipl_n=3'b110 two cycles after the edge.
REQ-040 Channels 0 and 2 pending, MASK=7 -> ipl_n=3'b100; IACK with cpu_lvl=3 -> vpa_n low one cycle later, PEND=0x0001, ipl_n=3'b110 after AS rises.
REQ-041 Second src[0] edge before ack -> PEND=0x0101; W1C 0x0100 -> PEND=0x0001.
REQ-042 IACK with cpu_lvl=2 and nothing pending -> vpa_n asserted, PEND=0x8000.
REQ-043 W1C bit0 in the same cycle as a new ch0 edge -> PEND[0] stays 1; reset_n low during IACK -> vpa_n=1 and ipl_n=3'b111 at once.
